ct_ciu_l2_hpcp_regs: RTL

CT_CIU_L2_HPCP_REGS -- requirements
Module: ct_ciu_l2_hpcp_regs

---
 rtl/ct_ciu_l2_hpcp_regs.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ct_ciu_l2_hpcp_regs.sv
`default_nettype none
// ct_ciu_l2_hpcp_regs: L2 HPCP event counters, control/overflow registers and PIU access FSM.
// Revision 1.0
module ct_ciu_l2_hpcp_regs (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        piu_regs_sel,
  input  logic [15:0] piu_regs_op,
  input  logic [63:0] piu_regs_wdata,
  input  logic [3:0]  piu_regs_hpcp_cnt_en,
  input  logic [3:0]  l2c_regs_hpcp_evt,
  output logic        regs_piu_cmplt,
  output logic [63:0] regs_piux_rdata,
  output logic [3:0]  regs_piu_hpcp_l2of_int
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    CMPLT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [11:0] C_CTRL_MASK = 12'hF0F;
  localparam logic [47:0] C_CNT_MAX   = 48'hFFFF_FFFF_FFFF;

  state_t            state_q;
  logic [3:0][47:0]  cnt_q, cnt_d;
  logic [11:0]       ctrl_q, ctrl_d;
  logic [3:0]        ovf_q, ovf_d;
  logic [3:0]        int_q;
  logic              cmplt_q;
  logic [63:0]       rdata_q;

  logic [7:0]  w_sel;
  logic [2:0]  w_csr;
  logic        w_wt;
  logic        w_legal;
  logic        w_do_write;
  logic [47:0] w_mux;
  logic [47:0] w_old;
  logic [47:0] w_new;
  logic [47:0] w_wd;
  logic [3:0]  w_inc;
  logic        w_unused_in;

  assign w_sel       = piu_regs_op[11:4];
  assign w_csr       = piu_regs_op[2:0];
  assign w_wt        = piu_regs_op[3];
  assign w_wd        = piu_regs_wdata[47:0];
  assign w_unused_in = ^{piu_regs_op[15:12], piu_regs_wdata[63:48]};

  // A read (WT=0) is legal with any op bits; a write needs exactly one CSR op.
  assign w_legal    = $onehot(w_sel) && (!w_wt || $onehot(w_csr));
  assign w_do_write = (state_q == ACC) && w_legal && w_wt;
  assign w_inc      = piu_regs_hpcp_cnt_en & ctrl_q[3:0] & l2c_regs_hpcp_evt;

  always_comb begin
    w_mux = 48'd0;
    case (w_sel)
      8'h01:   w_mux = cnt_q[0];
      8'h02:   w_mux = cnt_q[1];
      8'h04:   w_mux = cnt_q[2];
      8'h08:   w_mux = cnt_q[3];
      8'h10:   w_mux = {36'd0, ctrl_q};
      8'h20:   w_mux = {44'd0, ovf_q};
      default: w_mux = 48'd0;
    endcase
  end

  assign w_old = w_legal ? w_mux : 48'd0;
  assign w_new = w_csr[2] ? w_wd :
                 w_csr[1] ? (w_old | w_wd) : (w_old & ~w_wd);

  // Software write beats a same-edge increment; hardware overflow set beats a software clear.
  always_comb begin
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (w_do_write && w_sel[4]) ctrl_d = w_new[11:0] & C_CTRL_MASK;
    if (w_do_write && w_sel[5]) ovf_d  = w_new[3:0];
    for (int i = 0; i < 4; i++) begin
      if (w_do_write && w_sel[i]) begin
        cnt_d[i] = w_new;
      end else if (w_inc[i]) begin
        cnt_d[i] = cnt_q[i] + 48'd1;
        if (cnt_q[i] == C_CNT_MAX) ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 12'd0;
      ovf_q   <= 4'd0;
      int_q   <= 4'd0;
      cmplt_q <= 1'b0;
      rdata_q <= 64'd0;
    end else begin
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      ovf_q   <= ovf_d;
      int_q   <= ovf_q & ctrl_q[11:8];
      cmplt_q <= 1'b0;
      rdata_q <= 64'd0;
      case (state_q)
        IDLE:  if (piu_regs_sel) state_q <= ACC;
        ACC: begin
          state_q <= CMPLT;
          cmplt_q <= 1'b1;
          rdata_q <= {16'd0, w_old};
        end
        CMPLT: state_q <= WAIT;
        WAIT:  if (!piu_regs_sel) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign regs_piu_cmplt         = cmplt_q;
  assign regs_piux_rdata        = rdata_q;
  assign regs_piu_hpcp_l2of_int = int_q;

endmodule
`default_nettype wire
